// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - Default values for the sequencer parameters.
//   - FSM state encodings (3-bit localparam constants).
//   - max3(): helper used to size the shared cycle counter.
package pll_reset_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 32;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES    = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET_PLL = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_SETTLE    = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAIL      = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer: a STAGES-deep flop chain bringing an asynchronous
// level into the clk domain. STAGES must be at least 2.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears the whole chain
//   d   - asynchronous input level
//   q   - synchronized output (last flop of the chain)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, requires a
// stable lock window before releasing the system reset, retries a bounded
// number of times and parks in FAIL when the PLL never locks.
// Ports:
//   clk            - free-running reference clock (also the PLL refclk)
//   rst            - synchronous active-high reset
//   pll_locked     - PLL lock indication, asynchronous to clk
//   soft_reset_req - one-cycle request to restart the whole sequence
//   pll_rst        - reset to the PLL, active-high
//   sys_rst        - reset for the PLL-clocked logic, active-high
//   ready          - high only while running
//   fail           - high only in the FAIL state
//   lost_lock      - sticky: lock dropped while running
//   attempt        - failed lock attempts since last run / soft reset / rst
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [2:0] attempt
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  // Terminal counts: a state lasting N cycles sees the counter at 0..N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       ATT_MAX      = 3'(MAX_RETRIES);

  logic             locked_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       attempt_d;
  logic [2:0]       attempt_inc;
  logic             lost_lock_d;

  function automatic logic [2:0] sat_inc(input logic [2:0] a);
    return (a >= ATT_MAX) ? a : a + 3'd1;
  endfunction

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    attempt_d   = attempt;
    attempt_inc = sat_inc(attempt);
    lost_lock_d = lost_lock;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (locked_s) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          attempt_d = attempt_inc;
          state_d   = (attempt_inc == ATT_MAX) ? ST_FAIL : ST_RESET_PLL;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = ST_RUN;
          attempt_d = 3'd0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          lost_lock_d = 1'b1;
          state_d     = ST_RESET_PLL;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    // Soft reset overrides every lock/timeout decision above and always
    // restarts the PLL reset pulse from zero, even if already in RESET_PLL.
    if (soft_reset_req) begin
      state_d     = ST_RESET_PLL;
      attempt_d   = 3'd0;
      lost_lock_d = 1'b0;
    end

    if (soft_reset_req || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      attempt   <= 3'd0;
      lost_lock <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      attempt   <= attempt_d;
      lost_lock <= lost_lock_d;
      pll_rst   <= (state_d == ST_RESET_PLL);
      sys_rst   <= (state_d != ST_RUN);
      ready     <= (state_d == ST_RUN);
      fail      <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Cycle numbers are counted from the release of rst: cycle 0 is the first
// cycle with rst low; inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lost_lock;
  logic [2:0] attempt;

  int checks;
  int failures;
  int cyc;

  pll_reset_sequencer #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fail           (fail),
    .lost_lock      (lost_lock),
    .attempt        (attempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_pll_rst"},   pll_rst,   1'b1);
    chk1({tag, "_sys_rst"},   sys_rst,   1'b1);
    chk1({tag, "_ready"},     ready,     1'b0);
    chk1({tag, "_fail"},      fail,      1'b0);
    chk1({tag, "_lost_lock"}, lost_lock, 1'b0);
    chk3({tag, "_attempt"},   attempt,   3'd0);
  endtask

  // Hold rst for three edges, check reset outputs, then release (cycle 0).
  task automatic reset_release();
    rst = 1'b1;
    soft_reset_req = 1'b0;
    pll_locked = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    soft_reset_req = 1'b0;

    // Normal lock, lock loss in RUN, soft reset colliding with SETTLE end
    reset_release();
    for (int c = 0; c < 4; c++) begin
      go_to(c);
      chk1("a_pll_rst_pulse", pll_rst, 1'b1);
    end
    go_to(4);  chk1("a_pll_rst_end", pll_rst, 1'b0);
    go_to(6);  pll_locked = 1'b1;
    go_to(16); chk1("a_ready_early", ready, 1'b0);
               chk1("a_sys_rst_early", sys_rst, 1'b1);
    go_to(17); chk1("a_ready_rise", ready, 1'b1);
               chk1("a_sys_rst_fall", sys_rst, 1'b0);
               chk3("a_attempt_zero", attempt, 3'd0);
               chk1("a_lost_lock_clr", lost_lock, 1'b0);
    go_to(20); pll_locked = 1'b0;
    go_to(22); chk1("a_sys_rst_still_low", sys_rst, 1'b0);
               chk1("a_lost_lock_not_yet", lost_lock, 1'b0);
    go_to(23); chk1("a_sys_rst_on_loss", sys_rst, 1'b1);
               chk1("a_lost_lock_set", lost_lock, 1'b1);
               chk1("a_pll_rst_on_loss", pll_rst, 1'b1);
               chk1("a_ready_drop", ready, 1'b0);
               pll_locked = 1'b1;
    go_to(26); chk1("a_pll_rst_pulse2", pll_rst, 1'b1);
    go_to(27); chk1("a_pll_rst_end2", pll_rst, 1'b0);
    go_to(35); chk1("a_ready_early2", ready, 1'b0);
    go_to(36); chk1("a_ready_rerun", ready, 1'b1);
               chk1("a_lost_lock_sticky", lost_lock, 1'b1);
    go_to(40); pll_locked = 1'b0;
    go_to(43); chk1("a_lost_lock_again", lost_lock, 1'b1);
               chk1("a_pll_rst_pulse3", pll_rst, 1'b1);
               pll_locked = 1'b1;
    go_to(47); chk1("a_pll_rst_end3", pll_rst, 1'b0);
    go_to(55); chk1("a_ready_before_coll", ready, 1'b0);
               soft_reset_req = 1'b1;
    go_to(56); soft_reset_req = 1'b0;
               chk1("a_coll_no_run", ready, 1'b0);
               chk1("a_coll_pll_rst", pll_rst, 1'b1);
               chk1("a_coll_lost_lock_clr", lost_lock, 1'b0);
               chk1("a_coll_sys_rst", sys_rst, 1'b1);
    go_to(59); chk1("a_coll_pulse_hold", pll_rst, 1'b1);
    go_to(60); chk1("a_coll_pulse_end", pll_rst, 1'b0);
    go_to(68); chk1("a_coll_ready_early", ready, 1'b0);
    go_to(69); chk1("a_coll_ready", ready, 1'b1);
               chk1("a_coll_lost_lock_run", lost_lock, 1'b0);

    // Never locks: three retries then FAIL; soft reset leaves FAIL
    reset_release();
    go_to(4);  chk1("b_pll_rst_end1", pll_rst, 1'b0);
    go_to(23); chk1("b_wait_end1", pll_rst, 1'b0);
               chk3("b_attempt0", attempt, 3'd0);
    go_to(24); chk1("b_pll_rst_start2", pll_rst, 1'b1);
               chk3("b_attempt1", attempt, 3'd1);
    go_to(27); chk1("b_pll_rst_hold2", pll_rst, 1'b1);
    go_to(28); chk1("b_pll_rst_end2", pll_rst, 1'b0);
    go_to(48); chk1("b_pll_rst_start3", pll_rst, 1'b1);
               chk3("b_attempt2", attempt, 3'd2);
    go_to(52); chk1("b_pll_rst_end3", pll_rst, 1'b0);
    go_to(71); chk1("b_fail_early", fail, 1'b0);
               chk3("b_attempt2_hold", attempt, 3'd2);
    go_to(72); chk1("b_fail_set", fail, 1'b1);
               chk3("b_attempt3", attempt, 3'd3);
               chk1("b_fail_sys_rst", sys_rst, 1'b1);
               chk1("b_fail_pll_rst", pll_rst, 1'b0);
               chk1("b_fail_ready", ready, 1'b0);
    go_to(75); pll_locked = 1'b1;
    go_to(80); chk1("b_fail_ignores_lock", fail, 1'b1);
               chk3("b_attempt_saturated", attempt, 3'd3);
               chk1("b_fail_sys_rst_hold", sys_rst, 1'b1);
               soft_reset_req = 1'b1;
    go_to(81); soft_reset_req = 1'b0;
               chk1("b_soft_fail_clr", fail, 1'b0);
               chk3("b_soft_attempt_clr", attempt, 3'd0);
               chk1("b_soft_pll_rst", pll_rst, 1'b1);
               chk1("b_soft_lost_lock", lost_lock, 1'b0);
    go_to(93); chk1("b_ready_early", ready, 1'b0);
    go_to(94); chk1("b_ready_after_soft", ready, 1'b1);
               chk3("b_attempt_run", attempt, 3'd0);

    // One-cycle lock glitch during SETTLE restarts the stable window
    reset_release();
    go_to(6);  pll_locked = 1'b1;
    go_to(13); pll_locked = 1'b0;
    go_to(14); pll_locked = 1'b1;
    go_to(17); chk1("c_no_early_run", ready, 1'b0);
    go_to(24); chk1("c_ready_early", ready, 1'b0);
               chk3("c_attempt_unchanged", attempt, 3'd0);
    go_to(25); chk1("c_ready_fresh", ready, 1'b1);
               chk1("c_sys_rst_fresh", sys_rst, 1'b0);

    // rst pulse mid-SETTLE: reset values next cycle, sequence restarts
    reset_release();
    go_to(6);  pll_locked = 1'b1;
    go_to(12); chk1("d_settle_pll_rst", pll_rst, 1'b0);
               rst = 1'b1;
    go_to(13); rst = 1'b0;
               check_reset_outputs("d_mid_rst");
    go_to(16); chk1("d_pll_rst_hold", pll_rst, 1'b1);
    go_to(17); chk1("d_pll_rst_end", pll_rst, 1'b0);
    go_to(25); chk1("d_ready_early", ready, 1'b0);
    go_to(26); chk1("d_ready_rerun", ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in the pll_locked synchronizer (minimum 2).
REQ-002 Parameter PLL_RST_CYCLES, default 32: clk cycles that pll_rst is held high per PLL reset pulse.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: clk cycles to wait for lock after a pll_rst pulse ends.
REQ-004 Parameter STABLE_CYCLES, default 1024: consecutive cycles of synchronized lock required before release.
REQ-005 Parameter MAX_RETRIES, default 4: lock attempts before entering FAIL (minimum 1).
REQ-006 clk  in  1  free-running board reference clock (the same clock that feeds the PLL refclk); the block's only clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 pll_locked  in  1  PLL lock indication; asynchronous to clk.
REQ-009 soft_reset_req  in  1  single-cycle synchronous request to restart the sequence.
REQ-010 pll_rst  out  1  reset to the PLL, active-high.
REQ-011 sys_rst  out  1  system reset for the PLL-clocked logic, active-high; the consumer synchronizes it into its own domain.
REQ-012 ready  out  1  high only in RUN.
REQ-013 fail  out  1  high only in FAIL.
REQ-014 lost_lock  out  1  sticky flag: lock was lost while in RUN.
REQ-015 attempt  out  3  lock attempts that have failed since the last RUN, soft_reset_req, or rst.

Function
REQ-016 pll_locked SHALL pass through a SYNC_STAGES flop chain (locked_s), and only locked_s SHALL be used.
REQ-017 The FSM SHALL have these states: RESET_PLL, WAIT_LOCK, SETTLE, RUN, FAIL.
REQ-018 One shared counter SHALL be used, of width clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))+1, and it SHALL be cleared on every state change.
REQ-019 RESET_PLL: pll_rst=1; after PLL_RST_CYCLES cycles in the state, go to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_rst=0.
REQ-021 WAIT_LOCK, locked_s=1: go to SETTLE.
REQ-022 WAIT_LOCK timeout: after LOCK_TIMEOUT cycles without lock, increment attempt; go to FAIL if the new attempt equals MAX_RETRIES, otherwise go to RESET_PLL.
REQ-023 SETTLE: after STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN and clear attempt.
REQ-024 SETTLE: any locked_s=0 cycle SHALL return the FSM to WAIT_LOCK without incrementing attempt.
REQ-025 RUN: sys_rst=0 and ready=1.
REQ-026 RUN, locked_s=0: set lost_lock and go to RESET_PLL.
REQ-027 FAIL: pll_rst=0, sys_rst=1, fail=1; the FSM leaves FAIL only on soft_reset_req or rst.
REQ-028 soft_reset_req in any state SHALL go to RESET_PLL, clear attempt and lost_lock, and take priority over every lock or timeout event in the same cycle.
REQ-029 sys_rst SHALL be 1 in every state except RUN.
REQ-030 All outputs SHALL be registered, decoded from the next state, and therefore valid in the same cycle as the state register.
REQ-031 From an event on locked_s to the output response SHALL be exactly 1 cycle.
REQ-032 attempt SHALL saturate at MAX_RETRIES and never wrap.

Reset
REQ-033 While rst=1, the state SHALL be RESET_PLL with the counter at 0, and the synchronizer chain and attempt cleared.
REQ-034 While rst=1: pll_rst=1, sys_rst=1, ready=0, fail=0, lost_lock=0.
REQ-035 rst SHALL override soft_reset_req and any in-progress state.
REQ-036 The first post-reset pll_rst pulse SHALL last a full PLL_RST_CYCLES, counted from the first cycle with rst=0.

Structure
REQ-037 The state enumeration and the default parameter constants SHALL live in the shared package pll_reset_pkg.
REQ-038 The synchronizer SHALL be a separate sub-module, sync_bit (parameter STAGES), reusable elsewhere.

Verification (SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-039 Release rst; raise pll_locked 6 cycles later and hold it -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 11 cycles after pll_locked rises; attempt=0.
REQ-040 Hold pll_locked=0 -> 3 pll_rst pulses of 4 cycles each; fail=1 at cycle 72 after release; attempt=3; sys_rst stays 1.
REQ-041 In SETTLE, drop pll_locked for 1 cycle after 5 stable cycles -> return to WAIT_LOCK; attempt unchanged; ready only after 8 fresh stable cycles.
REQ-042 In RUN, drop pll_locked -> sys_rst=1 and lost_lock=1 exactly 3 cycles later, followed by a 4-cycle pll_rst pulse; lost_lock stays set after the next RUN.
REQ-043 soft_reset_req in FAIL, and soft_reset_req in the same cycle that a SETTLE completes -> RESET_PLL in both cases; fail=0, attempt=0, lost_lock=0; no RUN entry in the collision cycle.
REQ-044 rst asserted mid-SETTLE for 1 cycle -> all outputs return to their reset values the next cycle; the full sequence then repeats.
